// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB4 bus bundle for apb_cmd_master.
// The master modport is the view of the APB master itself.
// The slave modport is the view of whatever drives commands and models the APB slave.
interface apb_cmd_master_if #(
  parameter int REGWIDTH   = 32,
  parameter int ADDR_WIDTH = 8
);
  // command stream
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [REGWIDTH-1:0]     cmd_wdata;
  logic [REGWIDTH/8-1:0]   cmd_strb;
  logic [2:0]              cmd_prot;
  // response stream
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [REGWIDTH-1:0]     rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;
  // APB4
  logic                    m_apb_psel;
  logic                    m_apb_penable;
  logic                    m_apb_pwrite;
  logic [ADDR_WIDTH-1:0]   m_apb_paddr;
  logic [REGWIDTH-1:0]     m_apb_pwdata;
  logic [REGWIDTH/8-1:0]   m_apb_pstrb;
  logic [2:0]              m_apb_pprot;
  logic                    m_apb_pready;
  logic [REGWIDTH-1:0]     m_apb_prdata;
  logic                    m_apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr,
    output m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
    input  m_apb_pready, m_apb_prdata, m_apb_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_paddr,
    input  m_apb_pwdata, m_apb_pstrb, m_apb_pprot,
    output m_apb_pready, m_apb_prdata, m_apb_pslverr
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 master: one valid/ready command becomes one APB
// transfer and one valid/ready response. An ACCESS-phase timeout guarantees
// a response even if the slave never raises pready.
module apb_cmd_master #(
  parameter int REGWIDTH   = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               rst,   // asynchronous, active-low
  apb_cmd_master_if.master   bus
);
  localparam int STRB_W = REGWIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [REGWIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]     r_pstrb;
  logic [2:0]            r_pprot;
  logic [REGWIDTH-1:0]   r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;

  logic w_cmd_hs;
  logic w_acc_ready;
  logic w_acc_timeout;

  assign w_cmd_hs      = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_acc_ready   = (r_state == ST_ACCESS) && bus.m_apb_pready;
  assign w_acc_timeout = (r_state == ST_ACCESS) && !bus.m_apb_pready && (r_cnt == CNT_LAST);

  // Control outputs decode straight from state so reset drops psel at once.
  assign bus.cmd_ready     = (r_state == ST_IDLE);
  assign bus.rsp_valid     = (r_state == ST_RESP);
  assign bus.m_apb_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign bus.m_apb_penable = (r_state == ST_ACCESS);
  assign bus.m_apb_pwrite  = r_pwrite;
  assign bus.m_apb_paddr   = r_paddr;
  assign bus.m_apb_pwdata  = r_pwdata;
  assign bus.m_apb_pstrb   = r_pstrb;
  assign bus.m_apb_pprot   = r_pprot;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.rsp_timeout   = r_rsp_timeout;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode for the transfer sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_next = ST_SETUP;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_acc_ready || w_acc_timeout) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_RESP;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Command latch, ACCESS timeout counter and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= 3'b000;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        // Reads drive zero data and zero strobes on the bus.
        r_cnt    <= '0;
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
        r_pstrb  <= bus.cmd_write ? bus.cmd_strb : '0;
        r_pprot  <= bus.cmd_prot;
      end
      if (w_acc_ready) begin
        r_rsp_rdata   <= r_pwrite ? '0 : bus.m_apb_prdata;
        r_rsp_err     <= bus.m_apb_pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_acc_timeout) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed, table-driven bench for apb_cmd_master (TIMEOUT = 16).
module tb_apb_cmd_master;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  apb_cmd_master_if #(.REGWIDTH(32), .ADDR_WIDTH(8)) bus ();

  apb_cmd_master #(.REGWIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;    // pready low cycles before pready; >= 100 means never
    logic        slverr;
    logic [31:0] sdata;    // slave prdata
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;    // handshake edge to first rsp_valid cycle
    int          e_acc;    // cycles with penable high
    logic [3:0]  e_pstrb;
    logic [31:0] e_pwdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command at the current negedge and act as the APB slave.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    int   lat;
    int   acc;
    int   phase_bad;
    check($sformatf("v%0d_cmd_ready", idx), bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.cmd_prot  = v.prot;
    bus.m_apb_pready = 1'b0;
    lat = -1;
    acc = 0;
    phase_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cyc = c;
      // scramble command fields: the master must use its latched copy
      bus.cmd_valid = 1'b0;
      bus.cmd_write = ~v.wr;
      bus.cmd_addr  = ~v.addr;
      bus.cmd_wdata = ~v.wdata;
      bus.cmd_strb  = ~v.strb;
      bus.cmd_prot  = ~v.prot;
      bus.m_apb_pready  = 1'b0;
      bus.m_apb_pslverr = 1'b0;
      bus.m_apb_prdata  = 32'h0;
      if (bus.rsp_valid) begin
        lat = cyc;
        break;
      end
      if (bus.m_apb_psel !== 1'b1) phase_bad++;
      if (bus.m_apb_penable !== (cyc == 1 ? 1'b0 : 1'b1)) phase_bad++;
      if (bus.m_apb_paddr !== v.addr) phase_bad++;
      if (bus.m_apb_pwrite !== v.wr) phase_bad++;
      if (bus.m_apb_pstrb !== v.e_pstrb) phase_bad++;
      if (bus.m_apb_pwdata !== v.e_pwdata) phase_bad++;
      if (bus.m_apb_pprot !== v.prot) phase_bad++;
      if (bus.cmd_ready !== 1'b0) phase_bad++;
      if (bus.m_apb_penable === 1'b1) begin
        if (acc == v.waits) begin
          bus.m_apb_pready  = 1'b1;
          bus.m_apb_pslverr = v.slverr;
          bus.m_apb_prdata  = v.sdata;
        end
        acc++;
      end
    end
    check($sformatf("v%0d_latency", idx), lat, v.e_lat);
    check($sformatf("v%0d_access_cycles", idx), acc, v.e_acc);
    check($sformatf("v%0d_phase_errors", idx), phase_bad, 0);
    check($sformatf("v%0d_rdata", idx), bus.rsp_rdata, v.e_rdata);
    check($sformatf("v%0d_err", idx), bus.rsp_err, v.e_err);
    check($sformatf("v%0d_timeout", idx), bus.rsp_timeout, v.e_to);
    check($sformatf("v%0d_psel_in_resp", idx), bus.m_apb_psel, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_b2b_cmd_ready", idx), bus.cmd_ready, 1'b1);
    check($sformatf("v%0d_rsp_dropped", idx), bus.rsp_valid, 1'b0);
  endtask

  initial begin
    int bad_valid;
    int bad_data;
    int bad_busy;
    n_tests = 0;
    n_fail  = 0;
    //            wr    addr   wdata         strb  prot    waits slverr sdata         e_rdata       e_err e_to  lat acc pstrb e_pwdata
    vecs[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b000, 0,   1'b0, 32'hAAAA5555, 32'h00000000, 1'b0, 1'b0, 3,  1,  4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 8'h08, 32'hFFFFFFFF, 4'hF, 3'b010, 3,   1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 6,  4,  4'h0, 32'h00000000};
    vecs[2] = '{1'b0, 8'h0C, 32'h01020304, 4'hA, 3'b001, 1,   1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0, 4,  2,  4'h0, 32'h00000000};
    vecs[3] = '{1'b0, 8'h10, 32'h00000000, 4'h0, 3'b000, 200, 1'b0, 32'h11111111, 32'h00000000, 1'b1, 1'b1, 18, 16, 4'h0, 32'h00000000};
    vecs[4] = '{1'b1, 8'hFC, 32'h0000A5A5, 4'h5, 3'b101, 2,   1'b1, 32'h77777777, 32'h00000000, 1'b1, 1'b0, 5,  3,  4'h5, 32'h0000A5A5};
    vecs[5] = '{1'b0, 8'h00, 32'h99999999, 4'h3, 3'b111, 0,   1'b0, 32'h0BADBEEF, 32'h0BADBEEF, 1'b0, 1'b0, 3,  1,  4'h0, 32'h00000000};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    bus.cmd_prot  = 3'b000;
    bus.rsp_ready = 1'b0;
    bus.m_apb_pready  = 1'b0;
    bus.m_apb_prdata  = 32'h0;
    bus.m_apb_pslverr = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_psel", bus.m_apb_psel, 1'b0);
    check("rst_penable", bus.m_apb_penable, 1'b0);
    check("rst_pwrite", bus.m_apb_pwrite, 1'b0);
    check("rst_paddr", bus.m_apb_paddr, 8'h00);
    check("rst_pwdata", bus.m_apb_pwdata, 32'h0);
    check("rst_pstrb", bus.m_apb_pstrb, 4'h0);
    check("rst_pprot", bus.m_apb_pprot, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // response backpressure with a command pulse while busy
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h20;
    bus.cmd_strb  = 4'h0;
    bus.cmd_prot  = 3'b000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.m_apb_pready = 1'b1;
    bus.m_apb_prdata = 32'h55AA55AA;
    @(negedge clk);
    bus.m_apb_pready = 1'b0;
    bus.m_apb_prdata = 32'h0;
    check("bp_rsp_valid", bus.rsp_valid, 1'b1);
    check("bp_rdata", bus.rsp_rdata, 32'h55AA55AA);
    bad_valid = 0;
    bad_data  = 0;
    bad_busy  = 0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = (i == 2);
      bus.cmd_addr  = 8'h30;
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1) bad_valid++;
      if (bus.rsp_rdata !== 32'h55AA55AA || bus.rsp_err !== 1'b0 || bus.rsp_timeout !== 1'b0) bad_data++;
      if (bus.cmd_ready !== 1'b0 || bus.m_apb_psel !== 1'b0) bad_busy++;
    end
    check("bp_valid_held", bad_valid, 0);
    check("bp_fields_stable", bad_data, 0);
    check("bp_not_accepting", bad_busy, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h24;
    bus.cmd_wdata = 32'h11223344;
    bus.cmd_strb  = 4'h3;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_after_cmd_ready", bus.cmd_ready, 1'b1);
    check("bp_after_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("bp_next_psel", bus.m_apb_psel, 1'b1);
    check("bp_next_penable", bus.m_apb_penable, 1'b0);
    check("bp_next_paddr", bus.m_apb_paddr, 8'h24);
    check("bp_next_pstrb", bus.m_apb_pstrb, 4'h3);
    @(negedge clk);
    bus.m_apb_pready = 1'b1;
    bus.m_apb_prdata = 32'hFFFF0000;
    @(negedge clk);
    bus.m_apb_pready = 1'b0;
    check("bp_next_rsp_valid", bus.rsp_valid, 1'b1);
    check("bp_next_rdata", bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // asynchronous reset in the middle of ACCESS
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h40;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("mr_in_access", bus.m_apb_penable, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_psel", bus.m_apb_psel, 1'b0);
    check("mr_penable", bus.m_apb_penable, 1'b0);
    check("mr_rsp_valid", bus.rsp_valid, 1'b0);
    check("mr_cmd_ready", bus.cmd_ready, 1'b1);
    check("mr_paddr", bus.m_apb_paddr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB4 master that turns a valid/ready command stream into APB transfers and returns a valid/ready response stream. It sits directly upstream of the generated register block's `s_apb_*` slave port, driving its psel/penable/paddr/pwdata/pstrb/pprot and consuming its pready/prdata/pslverr. A built-in access timeout guarantees a response even when the slave never asserts pready.

## Interface

**Parameters**
- REGWIDTH, 32, data width in bits; multiple of 8.
- ADDR_WIDTH, 8, APB address width.
- TIMEOUT, 16, maximum ACCESS-phase cycles waited for pready; ≥1.

**Ports**
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  byte address.
- cmd_wdata  input  REGWIDTH  write data.
- cmd_strb  input  REGWIDTH/8  write byte strobes.
- cmd_prot  input  3  protection attributes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  output  REGWIDTH  read data; 0 for writes and timeouts.
- rsp_err  output  1  pslverr seen, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- m_apb_psel, m_apb_penable, m_apb_pwrite  output  1  APB control.
- m_apb_paddr  output  ADDR_WIDTH  APB address.
- m_apb_pwdata  output  REGWIDTH  APB write data.
- m_apb_pstrb  output  REGWIDTH/8  APB strobes.
- m_apb_pprot  output  3  APB protection.
- m_apb_pready  input  1  slave ready.
- m_apb_prdata  input  REGWIDTH  slave read data.
- m_apb_pslverr  input  1  slave error.

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered or decoded from state.
- **IDLE:** cmd_ready=1. On handshake, latch write/addr/wdata/strb/prot and go to SETUP.
- **SETUP:** psel=1, penable=0. Always go to ACCESS on the next cycle.
- **ACCESS:** psel=1, penable=1. The timeout counter increments every cycle.
  - pready=1: capture prdata (reads only, else 0) and pslverr into the response; go to RESP.
  - Counter reaches TIMEOUT-1 without pready: rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
- **RESP:** psel=penable=0, rsp_valid=1, response fields held stable. On rsp_valid && rsp_ready, go to IDLE.
- **Strobes:** pstrb = latched strb for writes; forced to 0 for reads (APB4 rule). pwdata for reads is don't-care and driven 0.
- **Address/control stability:** paddr, pwrite, pwdata, pstrb and pprot hold constant from SETUP through the end of ACCESS.
- **Outstanding limit:** one transfer at a time. cmd_ready=0 in SETUP, ACCESS and RESP.
- **Counter:** width $clog2(TIMEOUT)+1; cleared on entry to SETUP.
- **Late pready:** a pready arriving after a timeout is ignored, because psel is already low.

## Timing

- **Reset (rst low):** state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, all m_apb_* outputs 0, counter 0. Takes effect immediately, including mid-transfer, and drops psel asynchronously.
- **Zero-wait transfer:** handshake at edge 0 → SETUP in cycle 1 → ACCESS with pready in cycle 2 → rsp_valid=1 in cycle 3. Handshake to response latency is 3 cycles.
- **Wait states:** each cycle of pready=0 in ACCESS adds 1 cycle of latency.
- **Timeout:** with pready held low, rsp_valid rises TIMEOUT+2 cycles after the handshake.
- **Back-to-back:** if rsp_ready=1 in the first RESP cycle, cmd_ready is 1 in the next cycle. Minimum command period is 4 cycles.
- **Response backpressure:** rsp_valid stays high and the response fields do not change until rsp_ready=1.
- **Command during busy:** cmd_valid asserted outside IDLE is not accepted. Command fields need not stay stable until cmd_ready=1.

## Test plan

- **Write 0xDEADBEEF to 0x04 with strb=0xF, zero-wait slave:** psel in cycle 1, penable in cycle 2, paddr=0x04, pstrb=0xF, pwrite=1 throughout; rsp_valid in cycle 3 with err=0, rdata=0.
- **Read 0x08, slave returns 0x12345678 after 3 wait states:** pstrb=0 during the transfer; rsp_valid 6 cycles after the handshake with rsp_rdata=0x12345678, err=0.
- **Read with pslverr=1 at pready:** rsp_err=1, rsp_timeout=0.
- **TIMEOUT=16, pready tied low:** psel drops after 16 ACCESS cycles; rsp_valid with err=1, timeout=1, rdata=0. A subsequent command completes normally.
- **rsp_ready held low 5 cycles, then cmd_valid pulsed:** response stable throughout and cmd_ready=0. After the response handshake the next command is accepted in the following cycle.
- **rst asserted during ACCESS:** psel and penable go low immediately, rsp_valid=0 and cmd_ready=1; after release the next transfer behaves as in the first scenario.
